// File: rtl/regfile.sv
// Architectural register file with rename tags for an out-of-order core.
// Optional macro REGFILE_COMMIT_BYPASS_EN forwards a same-cycle commit into the query ports.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_rdy,
  input  logic              in_flush_enable,
  input  logic [4:0]        in_decoder_rs,
  input  logic [4:0]        in_decoder_rt,
  output logic [DATA_W-1:0] out_decoder_rs_value,
  output logic [DATA_W-1:0] out_decoder_rt_value,
  output logic [ROB_W-1:0]  out_decoder_rs_reorder,
  output logic [ROB_W-1:0]  out_decoder_rt_reorder,
  output logic              out_decoder_rs_busy,
  output logic              out_decoder_rt_busy,
  input  logic              in_decoder_rename_enable,
  input  logic [4:0]        in_decoder_rename_rd,
  input  logic [ROB_W-1:0]  in_decoder_rename_reorder,
  input  logic              in_rob_commit_enable,
  input  logic [4:0]        in_rob_commit_rd,
  input  logic [DATA_W-1:0] in_rob_commit_value,
  input  logic [ROB_W-1:0]  in_rob_commit_reorder,
  output logic [5:0]        out_pending_count
);

  localparam int NREG = 32;

  logic [NREG-1:0][DATA_W-1:0] val_q, val_d;
  logic [NREG-1:0][ROB_W-1:0]  tag_q, tag_d;
  logic [5:0]                  cnt_q, cnt_d;

  logic cmt_ok, ren_ok;
  assign cmt_ok = in_rdy && in_rob_commit_enable && (in_rob_commit_rd != 5'd0);
  assign ren_ok = in_rdy && in_decoder_rename_enable && (in_decoder_rename_rd != 5'd0)
                  && !in_flush_enable;

  // Order matters: commit clears first, rename then overrides, flush clears all tags.
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (cmt_ok) begin
      val_d[in_rob_commit_rd] = in_rob_commit_value;
      if (tag_q[in_rob_commit_rd] == in_rob_commit_reorder)
        tag_d[in_rob_commit_rd] = '0;
    end
    if (ren_ok)
      tag_d[in_decoder_rename_rd] = in_decoder_rename_reorder;
    if (in_rdy && in_flush_enable)
      tag_d = '0;
  end

  always_comb begin
    cnt_d = 6'd0;
    for (int i = 1; i < NREG; i++)
      cnt_d = cnt_d + {5'd0, (tag_d[i] != '0)};
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      val_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
    end else if (in_rdy) begin
      val_q <= val_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_pending_count = cnt_q;

  logic [1:0][4:0]        q_idx;
  logic [1:0][DATA_W-1:0] q_val;
  logic [1:0][ROB_W-1:0]  q_tag;

  assign q_idx = {in_decoder_rt, in_decoder_rs};

  for (genvar p = 0; p < 2; p++) begin : g_query
    always_comb begin
      q_val[p] = val_q[q_idx[p]];
      q_tag[p] = tag_q[q_idx[p]];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (cmt_ok && (q_idx[p] == in_rob_commit_rd) &&
          (tag_q[q_idx[p]] == in_rob_commit_reorder)) begin
        q_val[p] = in_rob_commit_value;
        q_tag[p] = '0;
      end
`endif
      if (q_idx[p] == 5'd0) begin
        q_val[p] = '0;
        q_tag[p] = '0;
      end
    end
  end

  assign out_decoder_rs_value   = q_val[0];
  assign out_decoder_rt_value   = q_val[1];
  assign out_decoder_rs_reorder = q_tag[0];
  assign out_decoder_rt_reorder = q_tag[1];
  assign out_decoder_rs_busy    = (q_tag[0] != '0);
  assign out_decoder_rt_busy    = (q_tag[1] != '0);

endmodule
